vga_rect_filler: RTL and testbench
==================================

Name: vga_rect_filler

Overview:
- Hardware rectangle-fill engine for the `vga_adapter` pixel-write port in the Tetris display path. It replaces tied-off `color`/`x`/`y`/`write` constants with a real pixel stream.
- It accepts one rectangle request per valid/ready handshake, clips it to the screen, and emits one pixel write per clock in row-major order.
- Downstream game logic uses it to paint cells, clear the playfield or clear the whole screen.

Parameters:
- X_RES, 160, horizontal resolution in pixels
- Y_RES, 120, vertical resolution in pixels
- NX, 8, x coordinate/width bit count
- NY, 7, y coordinate/height bit count
- COLOR_DEPTH, 9, pixel colour bits (3 per channel)

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept a request
- req_x  in  NX  top-left x
- req_y  in  NY  top-left y
- req_w  in  NX  width in pixels
- req_h  in  NY  height in pixels
- req_color  in  COLOR_DEPTH  fill colour
- req_clear  in  1  when 1: ignore x/y/w/h and fill the full X_RES x Y_RES screen
- px_x  out  NX  pixel x to `vga_adapter`
- px_y  out  NY  pixel y to `vga_adapter`
- px_color  out  COLOR_DEPTH  pixel colour
- px_write  out  1  pixel write strobe
- busy  out  1  request in progress (state != IDLE)
- done  out  1  one-cycle pulse when a request completes

Behaviour:
- The block has one clock; reset is synchronous and active-low.
- Reset (resetn=0 at a clock edge):
  - state=IDLE, req_ready=1, busy=0, done=0, px_write=0.
  - px_x=0, px_y=0, px_color=0.
  - Reset mid-draw aborts immediately: no further writes and no done pulse.
- States: IDLE, DRAW, DONE.
- IDLE:
  - req_ready=1.
  - Handshake on req_valid & req_ready at edge T; the request fields are latched.
- Clipping, computed at accept with NX+1 / NY+1 bit arithmetic (no wrap-around):
  - ew = min(req_w, X_RES - req_x); eh = min(req_h, Y_RES - req_y).
  - If req_x >= X_RES, req_y >= Y_RES, req_w == 0 or req_h == 0, then ew*eh=0.
  - In the zero-pixel case the engine goes straight to DONE at T+1 with no writes.
  - If req_clear=1: origin is (0,0), ew=X_RES, eh=Y_RES.
- DRAW:
  - Entered at T+1.
  - Each cycle: px_write=1 and px_x/px_y/px_color are valid in that same cycle.
  - x increments each cycle. When x reaches origin+ew-1, x resets to origin and y increments.
  - The last pixel is (origin_x+ew-1, origin_y+eh-1), written at cycle T+ew*eh.
  - Then the engine moves to DONE. No stall input exists; the adapter accepts a write every cycle.
- DONE:
  - Lasts exactly one cycle: done=1, px_write=0, req_ready=0, busy=1.
  - Then returns to IDLE. The next accept is possible at the edge ending the first IDLE cycle.
- Request timing:
  - req_valid while busy is ignored. The requester holds it; nothing is latched.
  - Throughput: ew*eh+2 cycles per request including DONE, plus one IDLE cycle.
- Outputs are registered. px_x/px_y/px_color hold their last values when px_write=0.
- Total latency from accept to done: ew*eh+1 cycles, or 1 cycle for zero-pixel requests.

Optional Feature:
- Macro: VGA_RECT_OUTLINE_EN.
- Defined:
  - Adds input port req_outline (1 bit), latched at accept.
  - When 1, the engine scans the clipped rectangle with identical timing, but px_write=1 only for edge pixels: x==origin_x, x==origin_x+ew-1, y==origin_y or y==origin_y+eh-1.
  - Interior cycles have px_write=0 while coordinates still advance.
  - req_clear overrides req_outline (full fill).
- Not defined: port absent; all requests are solid fills.

Decomposition:
- Package vga_pkg:
  - X_RES/Y_RES/NX/NY/COLOR_DEPTH default constants
  - fill state enum (IDLE, DRAW, DONE)
  - colour constants COLOR_BLACK=9'h000, COLOR_WHITE=9'h1FF
- One sub-module, vga_scan_counter: 2-D x/y counter with origin load, row-wrap and last-pixel flag. The FSM and clipping stay in the top.

Test Plan:
- Reset during DRAW of a 10x10 fill at cycle 5 → px_write=0 next cycle; no done pulse; req_ready=1; px_x=0.
- Request x=4, y=2, w=3, h=2, color=9'h1C0 → 6 writes at (4,2)(5,2)(6,2)(4,3)(5,3)(6,3) on cycles T+1..T+6; done at T+7.
- Clip: x=158, y=119, w=5, h=4 → writes only (158,119),(159,119); done at T+3.
- Zero size: w=0 or x=160 → no writes; done at T+1; req_ready=1 at T+2.
- req_clear=1, color=0 → 19200 writes covering (0,0)..(159,119) in row-major order; done at T+19201. Holding req_valid during busy gives no second accept until IDLE.
- With VGA_RECT_OUTLINE_EN: x=0, y=0, w=4, h=3, outline=1 → 12 scan cycles, 10 writes; interior (1,1),(2,1) have px_write=0; done at T+13.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the rectangle-fill engine that feeds vga_adapter.
package vga_pkg;

    localparam int X_RES       = 160;
    localparam int Y_RES       = 120;
    localparam int NX          = 8;
    localparam int NY          = 7;
    localparam int COLOR_DEPTH = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    localparam logic [COLOR_DEPTH-1:0] COLOR_BLACK = 9'h000;
    localparam logic [COLOR_DEPTH-1:0] COLOR_WHITE = 9'h1FF;

endpackage

// File: rtl/vga_scan_counter.sv
// Row-major 2-D pixel counter: loads an origin/extent, wraps rows at end_x,
// and flags the last pixel plus whether the next position lies on the rectangle edge.
module vga_scan_counter #(
    parameter int NX = 8,
    parameter int NY = 7
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load,
    input  logic          advance,
    input  logic [NX-1:0] org_x,
    input  logic [NY-1:0] org_y,
    input  logic [NX-1:0] end_x,
    input  logic [NY-1:0] end_y,
    output logic [NX-1:0] x,
    output logic [NY-1:0] y,
    output logic          last,
    output logic          edge_nxt
);

    logic [NX-1:0] x_r, org_x_r, end_x_r, x_nxt_s;
    logic [NY-1:0] y_r, org_y_r, end_y_r, y_nxt_s;

    // next scan position: step right, or wrap to the origin column of the next row
    always_comb begin
        if (x_r == end_x_r) begin
            x_nxt_s = org_x_r;
            y_nxt_s = y_r + NY'(1);
        end else begin
            x_nxt_s = x_r + NX'(1);
            y_nxt_s = y_r;
        end
    end

    assign x        = x_r;
    assign y        = y_r;
    assign last     = (x_r == end_x_r) && (y_r == end_y_r);
    assign edge_nxt = (x_nxt_s == org_x_r) || (x_nxt_s == end_x_r) ||
                      (y_nxt_s == org_y_r) || (y_nxt_s == end_y_r);

    // position and rectangle bounds registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_r     <= {NX{1'b0}};
            y_r     <= {NY{1'b0}};
            org_x_r <= {NX{1'b0}};
            org_y_r <= {NY{1'b0}};
            end_x_r <= {NX{1'b0}};
            end_y_r <= {NY{1'b0}};
        end else if (load) begin
            x_r     <= org_x;
            y_r     <= org_y;
            org_x_r <= org_x;
            org_y_r <= org_y;
            end_x_r <= end_x;
            end_y_r <= end_y;
        end else if (advance) begin
            x_r <= x_nxt_s;
            y_r <= y_nxt_s;
        end
    end

endmodule

// File: rtl/vga_rect_filler.sv
// Clipped rectangle-fill engine streaming one pixel write per clock to vga_adapter.
// Optional VGA_RECT_OUTLINE_EN adds req_outline for edge-only drawing.
module vga_rect_filler #(
    parameter int X_RES       = vga_pkg::X_RES,
    parameter int Y_RES       = vga_pkg::Y_RES,
    parameter int NX          = vga_pkg::NX,
    parameter int NY          = vga_pkg::NY,
    parameter int COLOR_DEPTH = vga_pkg::COLOR_DEPTH
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NX-1:0]          req_x,
    input  logic [NY-1:0]          req_y,
    input  logic [NX-1:0]          req_w,
    input  logic [NY-1:0]          req_h,
    input  logic [COLOR_DEPTH-1:0] req_color,
    input  logic                   req_clear,
`ifdef VGA_RECT_OUTLINE_EN
    input  logic                   req_outline,
`endif
    output logic [NX-1:0]          px_x,
    output logic [NY-1:0]          px_y,
    output logic [COLOR_DEPTH-1:0] px_color,
    output logic                   px_write,
    output logic                   busy,
    output logic                   done
);

    import vga_pkg::*;

    localparam logic [NX:0] X_RES_V = (NX+1)'(X_RES);
    localparam logic [NY:0] Y_RES_V = (NY+1)'(Y_RES);

    fill_state_e   state_r, state_nxt_s;
    logic [NX:0]   rem_x_s, ew_s;
    logic [NY:0]   rem_y_s, eh_s;
    logic [NX-1:0] org_x_s, end_x_s;
    logic [NY-1:0] org_y_s, end_y_s;
    logic          empty_s, load_s, adv_s, px_write_nxt_s, done_nxt_s;
    logic          last_s, edge_nxt_s, outline_s;

    // clip the incoming request against the screen in one-bit-wider arithmetic
    always_comb begin
        rem_x_s = X_RES_V - {1'b0, req_x};
        rem_y_s = Y_RES_V - {1'b0, req_y};
        if (req_clear) begin
            org_x_s = {NX{1'b0}};
            org_y_s = {NY{1'b0}};
            ew_s    = X_RES_V;
            eh_s    = Y_RES_V;
        end else begin
            org_x_s = req_x;
            org_y_s = req_y;
            if ({1'b0, req_x} >= X_RES_V)     ew_s = {(NX+1){1'b0}};
            else if ({1'b0, req_w} < rem_x_s) ew_s = {1'b0, req_w};
            else                              ew_s = rem_x_s;
            if ({1'b0, req_y} >= Y_RES_V)     eh_s = {(NY+1){1'b0}};
            else if ({1'b0, req_h} < rem_y_s) eh_s = {1'b0, req_h};
            else                              eh_s = rem_y_s;
        end
        empty_s = (ew_s == {(NX+1){1'b0}}) || (eh_s == {(NY+1){1'b0}});
        end_x_s = NX'({1'b0, org_x_s} + ew_s - (NX+1)'(1));
        end_y_s = NY'({1'b0, org_y_s} + eh_s - (NY+1)'(1));
    end

`ifdef VGA_RECT_OUTLINE_EN
    logic outline_r;

    // outline mode is latched with the request; a full-screen clear always fills
    always_ff @(posedge clock) begin
        if (!resetn)     outline_r <= 1'b0;
        else if (load_s) outline_r <= req_outline & ~req_clear;
    end
    assign outline_s = outline_r;
`else
    assign outline_s = 1'b0;
`endif

    vga_scan_counter #(.NX(NX), .NY(NY)) u_scan (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load_s),
        .advance  (adv_s),
        .org_x    (org_x_s),
        .org_y    (org_y_s),
        .end_x    (end_x_s),
        .end_y    (end_y_s),
        .x        (px_x),
        .y        (px_y),
        .last     (last_s),
        .edge_nxt (edge_nxt_s)
    );

    // next-state and next-output decode
    always_comb begin
        state_nxt_s    = state_r;
        load_s         = 1'b0;
        adv_s          = 1'b0;
        px_write_nxt_s = 1'b0;
        done_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (empty_s) begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s    = DRAW;
                        load_s         = 1'b1;
                        px_write_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAW: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    adv_s          = 1'b1;
                    px_write_nxt_s = ~outline_s | edge_nxt_s;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // state and registered handshake/strobe outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            px_write  <= 1'b0;
            px_color  <= {COLOR_DEPTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            req_ready <= (state_nxt_s == IDLE);
            busy      <= (state_nxt_s != IDLE);
            done      <= done_nxt_s;
            px_write  <= px_write_nxt_s;
            if (load_s) px_color <= req_color;
        end
    end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed self-checking bench for vga_rect_filler with hand-computed pixel streams.
module tb_vga_rect_filler;
    import vga_pkg::*;

    logic       clock = 1'b0;
    logic       resetn, req_valid, req_ready, req_clear, req_outline;
    logic [7:0] req_x, req_w, px_x;
    logic [6:0] req_y, req_h, px_y;
    logic [8:0] req_color, px_color;
    logic       px_write, busy, done;
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         act_cnt;

    always #10 clock = ~clock;

    vga_rect_filler dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_color (req_color),
        .req_clear (req_clear),
`ifdef VGA_RECT_OUTLINE_EN
        .req_outline (req_outline),
`endif
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color),
        .px_write  (px_write),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // present a request at a negedge; returns #1 after the accepting edge (cycle T+1)
    task automatic do_req(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                          input logic [6:0] h, input logic [8:0] c, input logic clr,
                          input logic outl, input bit hold);
        @(negedge clock);
        req_x = x; req_y = y; req_w = w; req_h = h;
        req_color = c; req_clear = clr; req_outline = outl; req_valid = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // expected row-major scan of the clipped rectangle, then DONE and IDLE cycles
    task automatic expect_scan(input int ox, input int oy, input int ew, input int eh,
                               input logic outl, input logic [8:0] c, input string tag);
        int n = ew * eh;
        int errs = 0;
        logic wr;
        logic [26:0] obs, exp;
        if (n > 0) begin
            for (int j = 0; j < eh; j++) begin
                for (int i = 0; i < ew; i++) begin
                    if (i != 0 || j != 0) begin
                        @(posedge clock);
                        #1;
                    end
                    wr  = !outl || (i == 0) || (i == ew - 1) || (j == 0) || (j == eh - 1);
                    obs = {busy, req_ready, px_write, px_x, px_y, px_color};
                    exp = {1'b1, 1'b0, wr, 8'(ox + i), 7'(oy + j), c};
                    if (n <= 16) check($sformatf("%s_px%0d", tag, j * ew + i), 32'(obs), 32'(exp));
                    else if (obs !== exp) errs++;
                end
            end
            if (n > 16) check({tag, "_errs"}, 32'(errs), 32'd0);
            @(posedge clock);
            #1;
        end
        check({tag, "_done"}, {28'd0, done, px_write, req_ready, busy}, 32'h9);
        @(posedge clock);
        #1;
        check({tag, "_idle"}, {28'd0, done, px_write, req_ready, busy}, 32'h2);
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_clear = 1'b0; req_outline = 1'b0;
        req_x = 8'd0; req_y = 7'd0; req_w = 8'd0; req_h = 7'd0; req_color = 9'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", 32'({done, px_write, req_ready, busy, px_x, px_y, px_color}),
              32'({4'b0010, 8'd0, 7'd0, 9'd0}));
        @(negedge clock);
        resetn = 1'b1;

        do_req(8'd4, 7'd2, 8'd3, 7'd2, 9'h1C0, 1'b0, 1'b0, 1'b0);
        expect_scan(4, 2, 3, 2, req_outline, 9'h1C0, "rect");

        do_req(8'd10, 7'd10, 8'd0, 7'd5, 9'h0AA, 1'b0, 1'b0, 1'b0);
        expect_scan(10, 10, 0, 5, req_outline, 9'h0AA, "zero_w");
        check("hold_px", 32'({px_x, px_y, px_color}), 32'({8'd6, 7'd3, 9'h1C0}));

        do_req(8'd160, 7'd5, 8'd4, 7'd4, 9'h0AA, 1'b0, 1'b0, 1'b0);
        expect_scan(160, 5, 0, 4, req_outline, 9'h0AA, "zero_x");

        do_req(8'd158, 7'd119, 8'd5, 7'd4, 9'h038, 1'b0, 1'b0, 1'b0);
        expect_scan(158, 119, 2, 1, req_outline, 9'h038, "clip");

`ifdef VGA_RECT_OUTLINE_EN
        do_req(8'd0, 7'd0, 8'd4, 7'd3, COLOR_WHITE, 1'b0, 1'b1, 1'b0);
        expect_scan(0, 0, 4, 3, req_outline, COLOR_WHITE, "outline");
`endif

        do_req(8'd50, 7'd50, 8'd3, 7'd3, COLOR_BLACK, 1'b1, 1'b0, 1'b1);
        expect_scan(0, 0, 160, 120, req_outline, COLOR_BLACK, "clear");

        // valid still held: new fields are taken at the edge ending the IDLE cycle
        @(negedge clock);
        req_clear = 1'b0; req_x = 8'd10; req_y = 7'd10; req_w = 8'd10; req_h = 7'd10;
        req_color = COLOR_WHITE;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check("reaccept", 32'({busy, px_write, px_x, px_y}), 32'({1'b1, 1'b1, 8'd10, 7'd10}));
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        check("pre_rst_x", 32'(px_x), 32'd14);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check("rst_abort", 32'({done, px_write, req_ready, busy, px_x, px_y, px_color}),
              32'({4'b0010, 8'd0, 7'd0, 9'd0}));
        @(negedge clock);
        resetn = 1'b1;
        act_cnt = 0;
        repeat (150) begin
            @(posedge clock);
            #1;
            if (done || px_write) act_cnt++;
        end
        check("no_done_after_rst", 32'(act_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
